// File: rtl/fifo_sync_pack.sv
// Synchronous FIFO with a write-side packer that gathers pRATIO narrow words per storage word.
// Optional high-water tracking of the fill count is enabled by defining FIFO_PACK_HIGHWATER_EN.
module fifo_sync_pack #(
    parameter int pIN_WIDTH    = 16,
    parameter int pRATIO       = 2,
    parameter int pDEPTH       = 256,
    parameter int pFALLTHROUGH = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     full_threshold_value,
    input  logic                            wen,
    input  logic [pIN_WIDTH-1:0]            wdata,
    input  logic                            wlast,
    output logic                            full,
    output logic                            almost_full,
    output logic                            full_threshold,
    output logic                            overflow,
    input  logic                            ren,
    output logic [pIN_WIDTH*pRATIO-1:0]     rdata,
    output logic                            empty,
    output logic                            almost_empty,
    output logic                            underflow,
    output logic [$clog2(pDEPTH):0]         count,
    output logic [$clog2(pRATIO):0]         pack_level,
    output logic [$clog2(pDEPTH):0]         max_fill
);

    localparam int OUT_W = pIN_WIDTH * pRATIO;
    localparam int AW    = $clog2(pDEPTH);
    localparam int CW    = AW + 1;
    localparam int LW    = $clog2(pRATIO) + 1;

    localparam logic [CW-1:0] DEPTH_C     = CW'(pDEPTH);
    localparam logic [CW-1:0] ALMOST_C    = CW'(pDEPTH - 1);
    localparam logic [CW-1:0] ONE_C       = CW'(1);
    localparam logic [LW-1:0] LAST_SLOT_C = LW'(pRATIO - 1);

    // Drops one narrow word into its slot; slots at and above 'slot' are known to be zero.
    function automatic logic [OUT_W-1:0] place_slot(
        input logic [OUT_W-1:0]     held,
        input logic [pIN_WIDTH-1:0] data,
        input logic [LW-1:0]        slot
    );
        return held | (OUT_W'(data) << (32'(slot) * pIN_WIDTH));
    endfunction

    logic                 wr_ok;
    logic                 push;
    logic                 pop;
    logic [OUT_W-1:0]     pack_reg;
    logic [OUT_W-1:0]     placed;
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [OUT_W-1:0]     head;
    logic [OUT_W-1:0]     mem [pDEPTH];

    assign wr_ok  = wen & ~full;
    assign push   = wr_ok & ((pack_level == LAST_SLOT_C) | wlast);
    assign placed = place_slot(pack_reg, wdata, pack_level);
    assign head   = mem[rptr];

    // ---- write stage: packer accumulation, cleared on every push so early-closed words zero-pad
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_reg   <= '0;
            pack_level <= '0;
        end else if (wr_ok) begin
            if (push) begin
                pack_reg   <= '0;
                pack_level <= '0;
            end else begin
                pack_reg   <= placed;
                pack_level <= pack_level + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= placed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
        end else if (push) begin
            wptr <= wptr + AW'(1);
        end
    end

    // ---- occupancy and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count + CW'(push) - CW'(pop);
            overflow  <= wen & full;
            underflow <= ren & empty;
        end
    end

    assign full           = (count == DEPTH_C);
    assign almost_full    = (count >= ALMOST_C);
    assign almost_empty   = (count <= ONE_C);
    assign full_threshold = (32'(count) >= full_threshold_value);

    // ---- read stage
    generate
        if (pFALLTHROUGH != 0) begin : g_fwft
            // rdata doubles as the head register; count includes the word it holds.
            logic out_vld;
            logic mem_has;
            logic load;

            assign mem_has = ((count - CW'(out_vld)) != '0);
            assign empty   = ~out_vld;
            assign pop     = ren & out_vld;
            assign load    = mem_has & (~out_vld | pop);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_vld <= 1'b0;
                    rdata   <= '0;
                    rptr    <= '0;
                end else if (load) begin
                    out_vld <= 1'b1;
                    rdata   <= head;
                    rptr    <= rptr + AW'(1);
                end else if (pop) begin
                    out_vld <= 1'b0;
                end
            end
        end else begin : g_reg
            assign empty = (count == '0);
            assign pop   = ren & ~empty;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata <= '0;
                    rptr  <= '0;
                end else if (pop) begin
                    rdata <= head;
                    rptr  <= rptr + AW'(1);
                end
            end
        end
    endgenerate

    // ---- high-water monitor, one cycle behind count
`ifdef FIFO_PACK_HIGHWATER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_fill <= '0;
        end else if (count > max_fill) begin
            max_fill <= count;
        end
    end
`else
    assign max_fill = '0;
`endif

endmodule
